// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Bit p/g are captured first, then GROUP-bit group lookahead, then per-bit carries and sum.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p_all,
  output logic             g_all
);
  localparam int NG = WIDTH / GROUP;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             adv1, adv2, adv3;

  logic [WIDTH-1:0] yy;
  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic             c0_q, c0_d;

  logic [NG-1:0]    grp_p, grp_g;
  logic             grp_c, all_g;
  logic [WIDTH-1:0] p2_q, p2_d, g2_q, g2_d;
  logic [NG-1:0]    gc2_q, gc2_d;
  logic             pall2_q, pall2_d, gall2_q, gall2_d;

  logic             bit_c, c_msb;
  logic [WIDTH-1:0] bit_s;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, p_all_q, p_all_d, g_all_q, g_all_d;

  // A stage may load when it is empty or its successor is moving, so bubbles collapse.
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign in_ready = adv1 && !rst;

  // NOTE: every _d gets its hold value first, so no path through the block can infer a latch.
  always_comb begin
    yy   = sub ? ~y : y;
    v1_d = v1_q;
    p1_d = p1_q;
    g1_d = g1_q;
    c0_d = c0_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        p1_d = x ^ yy;
        g1_d = x & yy;
        c0_d = sub || cin;
      end
    end
  end

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p[j] = &p1_q[j*GROUP +: GROUP];
      for (int k = 0; k < GROUP; k++)
        grp_g[j] = g1_q[j*GROUP+k] | (p1_q[j*GROUP+k] & grp_g[j]);
    end
  end

  // Group carry-ins chain from c0; the whole-word generate is the same chain seeded with 0.
  always_comb begin
    v2_d    = v2_q;
    p2_d    = p2_q;
    g2_d    = g2_q;
    gc2_d   = gc2_q;
    pall2_d = pall2_q;
    gall2_d = gall2_q;
    grp_c   = c0_q;
    all_g   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gc2_d[j] = grp_c;
      grp_c    = grp_g[j] | (grp_p[j] & grp_c);
      all_g    = grp_g[j] | (grp_p[j] & all_g);
    end
    if (!adv2) begin
      gc2_d = gc2_q;
    end else begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d    = p1_q;
        g2_d    = g1_q;
        pall2_d = &grp_p;
        gall2_d = all_g;
      end else begin
        gc2_d = gc2_q;
      end
    end
  end

  always_comb begin
    bit_c = 1'b0;
    c_msb = 1'b0;
    bit_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GROUP == 0) bit_c = gc2_q[i/GROUP];
      bit_s[i] = p2_q[i] ^ bit_c;
      if (i == WIDTH - 1) c_msb = bit_c;
      bit_c = g2_q[i] | (p2_q[i] & bit_c);
    end
  end

  always_comb begin
    v3_d    = v3_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    p_all_d = p_all_q;
    g_all_d = g_all_q;
    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        sum_d   = bit_s;
        cout_d  = bit_c;
        ovf_d   = c_msb ^ bit_c;
        p_all_d = pall2_q;
        g_all_d = gall2_q;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p1_q    <= '0;
      g1_q    <= '0;
      c0_q    <= 1'b0;
      p2_q    <= '0;
      g2_q    <= '0;
      gc2_q   <= '0;
      pall2_q <= 1'b0;
      gall2_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      p_all_q <= 1'b0;
      g_all_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      c0_q    <= c0_d;
      p2_q    <= p2_d;
      g2_q    <= g2_d;
      gc2_q   <= gc2_d;
      pall2_q <= pall2_d;
      gall2_q <= gall2_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      p_all_q <= p_all_d;
      g_all_q <= g_all_d;
    end
  end

  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign p_all     = p_all_q;
  assign g_all     = g_all_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vectors, reset, back-pressure stream and
// a parameter sweep, all scored against an arithmetic reference model.
module tb_cla_pipe_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        p_all;
    logic        g_all;
  } res_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    int          acc_cyc;
    bit          has_exp;
    res_t        exp;
  } beat_t;

  logic         clk;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic         cout, ovf, p_all, g_all;
  logic [W-1:0] x, y, sum;

  logic         sw_valid, sw_cin, sw_sub;
  logic [31:0]  sw_x, sw_y;
  logic         a_ir, a_ov, a_co, a_of, a_pa, a_ga;
  logic [7:0]   a_sum;
  logic         b_ir, b_ov, b_co, b_of, b_pa, b_ga;
  logic [7:0]   b_sum;
  logic         c_ir, c_ov, c_co, c_of, c_pa, c_ga;
  logic [31:0]  c_sum;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           accepted = 0;
  bit           lat_mode = 0;
  bit           dir_has = 0;
  res_t         dir_exp = '0;
  bit           stall_prev = 0;
  logic [W+4:0] prev_out = '0;
  beat_t        q_main[$];
  beat_t        q_sw[$];

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .p_all(p_all), .g_all(g_all));

  cla_pipe_adder #(.WIDTH(8), .GROUP(1)) dut_w8g1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(a_ir), .x(sw_x[7:0]), .y(sw_y[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(a_ov), .out_ready(1'b1), .sum(a_sum),
    .cout(a_co), .ovf(a_of), .p_all(a_pa), .g_all(a_ga));

  cla_pipe_adder #(.WIDTH(8), .GROUP(8)) dut_w8g8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(b_ir), .x(sw_x[7:0]), .y(sw_y[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(b_ov), .out_ready(1'b1), .sum(b_sum),
    .cout(b_co), .ovf(b_of), .p_all(b_pa), .g_all(b_ga));

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut_w32g4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(c_ir), .x(sw_x), .y(sw_y),
    .cin(sw_cin), .sub(sw_sub), .out_valid(c_ov), .out_ready(1'b1), .sum(c_sum),
    .cout(c_co), .ovf(c_of), .p_all(c_pa), .g_all(c_ga));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Plain wide arithmetic; overflow from operand/result signs.
  function automatic res_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
    res_t        r;
    logic [63:0] mask, aa, bb, tot, raw;
    mask    = (64'd1 << w) - 64'd1;
    aa      = {32'd0, a} & mask;
    bb      = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
    tot     = aa + bb + (sb ? 64'd1 : {63'd0, ci});
    raw     = aa + bb;
    r.sum   = 32'(tot & mask);
    r.cout  = tot[w];
    r.ovf   = (aa[w-1] == bb[w-1]) && (tot[w-1] != aa[w-1]);
    r.p_all = ((aa ^ bb) == mask);
    r.g_all = raw[w];
    return r;
  endfunction

  task automatic check_sw(input string tag, input int w, input beat_t bt, input logic [31:0] s,
                          input logic [3:0] flg);
    res_t e;
    e = ref_add(w, bt.x, bt.y, bt.cin, bt.sub);
    check({tag, "_sum"}, 64'(s), 64'(e.sum));
    check({tag, "_flags"}, 64'(flg), 64'({e.cout, e.ovf, e.p_all, e.g_all}));
  endtask

  // One cycle: score at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    beat_t bt;
    res_t  e;
    @(negedge clk);
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(!(q_main.size() == 3 && !out_ready)));
      if (stall_prev)
        check("stall_hold", 64'({out_valid, sum, cout, ovf, p_all, g_all}), 64'(prev_out));
      if (q_main.size() == 0) check("idle_valid", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && q_main.size() != 0) begin
        bt = q_main.pop_front();
        e  = bt.has_exp ? bt.exp : ref_add(W, bt.x, bt.y, bt.cin, bt.sub);
        check("sum", 64'(sum), 64'(e.sum));
        check("flags", 64'({cout, ovf, p_all, g_all}), 64'({e.cout, e.ovf, e.p_all, e.g_all}));
        if (lat_mode) check("latency", 64'(cyc - bt.acc_cyc), 64'd3);
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_valid, sum, cout, ovf, p_all, g_all};
      if (in_valid && in_ready) begin
        bt.x       = 32'(x);
        bt.y       = 32'(y);
        bt.cin     = cin;
        bt.sub     = sub;
        bt.acc_cyc = cyc;
        bt.has_exp = dir_has;
        bt.exp     = dir_exp;
        q_main.push_back(bt);
        accepted++;
      end
      if (a_ov) begin
        check("sw_valid", 64'({b_ov, c_ov}), 64'd3);
        if (q_sw.size() == 0) begin
          check("sw_spurious", 64'(a_ov), 64'd0);
        end else begin
          bt = q_sw.pop_front();
          check_sw("w8g1", 8, bt, 32'(a_sum), {a_co, a_of, a_pa, a_ga});
          check_sw("w8g8", 8, bt, 32'(b_sum), {b_co, b_of, b_pa, b_ga});
          check_sw("w32g4", 32, bt, c_sum, {c_co, c_of, c_pa, c_ga});
        end
      end
      if (sw_valid && a_ir) begin
        bt.x       = sw_x;
        bt.y       = sw_y;
        bt.cin     = sw_cin;
        bt.sub     = sw_sub;
        bt.acc_cyc = cyc;
        bt.has_exp = 1'b0;
        bt.exp     = '0;
        q_sw.push_back(bt);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({out_valid, in_ready, sum, cout, ovf, p_all, g_all}), 64'd0);
  endtask

  // Directed vectors: x, y, cin, sub -> sum, {cout, ovf, p_all, g_all}.
  logic [15:0] d_x   [6] = '{16'hFFFF, 16'hAAAA, 16'h7FFF, 16'h0005, 16'h8000, 16'h0001};
  logic [15:0] d_y   [6] = '{16'h0001, 16'h5555, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
  logic        d_cin [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        d_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] d_sum [6] = '{16'h0000, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
  logic [3:0]  d_flg [6] = '{4'b1001, 4'b1010, 4'b0100, 4'b0000, 4'b1101, 4'b1010};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_x = '0; sw_y = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_outs");
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Directed vectors back to back with out_ready held high: 3-cycle latency, full rate.
    lat_mode = 1'b1;
    dir_has  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = d_x[i]; y = d_y[i]; cin = d_cin[i]; sub = d_sub[i];
      dir_exp = '{sum: 32'(d_sum[i]), cout: d_flg[i][3], ovf: d_flg[i][2],
                  p_all: d_flg[i][1], g_all: d_flg[i][0]};
      tick();
    end
    in_valid = 1'b0;
    dir_has  = 1'b0;
    for (int i = 0; i < 8 && q_main.size() != 0; i++) tick();
    check("directed_drain", 64'(q_main.size()), 64'd0);
    lat_mode = 1'b0;

    // Fill the pipe while stalled, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    q_main.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();

    // Random stream under random back-pressure.
    accepted = 0;
    for (int it = 0; it < 3000 && accepted < 60; it++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = 1'($urandom_range(1));
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    check("stream_accepted", 64'(accepted), 64'd60);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q_main.size() != 0; i++) tick();
    check("stream_drain", 64'(q_main.size()), 64'd0);

    // Parameter sweep at full rate.
    sw_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      sw_x = $urandom; sw_y = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      tick();
    end
    sw_valid = 1'b0;
    for (int i = 0; i < 8 && q_sw.size() != 0; i++) tick();
    check("sweep_drain", 64'(q_sw.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL timeout @%0t: simulation did not complete", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
